// File: rtl/vga_timing_pkg.sv
// Shared 640x480 VGA raster timing constants and the colour type used by both
// this timing generator and the graphics generator feeding it.
package vga_timing_pkg;

    // Pixel clock divider: 100 MHz system clock down to the 25 MHz pixel rate.
    localparam int VGA_PIX_DIV = 4;

    // Horizontal timing, in pixels.
    localparam int VGA_H_DISP = 640;
    localparam int VGA_H_FP   = 16;
    localparam int VGA_H_SYNC = 96;
    localparam int VGA_H_BP   = 48;

    // Vertical timing, in lines.
    localparam int VGA_V_DISP = 480;
    localparam int VGA_V_FP   = 10;
    localparam int VGA_V_SYNC = 2;
    localparam int VGA_V_BP   = 33;

    // Sync pulses are active-low for this mode.
    localparam bit VGA_SYNC_POL = 1'b0;

    // Derived totals; both must fit the 10-bit raster counters.
    localparam int VGA_H_TOTAL = VGA_H_DISP + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_TOTAL = VGA_V_DISP + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    // Inclusive sync windows in counter coordinates (656..751, 490..491).
    localparam int VGA_H_SYNC_START = VGA_H_DISP + VGA_H_FP;
    localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC - 1;
    localparam int VGA_V_SYNC_START = VGA_V_DISP + VGA_V_FP;
    localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC - 1;

    localparam int COORD_W = 10;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [11:0]        rgb_t;

    localparam rgb_t RGB_BLACK = 12'h000;

    // Inclusive range test used for the sync window decode.
    function automatic logic in_window(coord_t val, coord_t lo, coord_t hi);
        return (val >= lo) && (val <= hi);
    endfunction

endpackage

// File: rtl/vga_pix_div.sv
// Modulo-PIX_DIV divider producing the one-clk-wide pixel enable.
module vga_pix_div
    import vga_timing_pkg::*;
#(
    parameter int PIX_DIV = VGA_PIX_DIV
) (
    input  logic clk,
    input  logic reset,
    output logic p_tick
);

    // A one-bit counter is kept even for PIX_DIV = 1; it then never leaves 0.
    localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

    logic [DIV_W-1:0] div_cnt;

    // Divider counter: 0..PIX_DIV-1, wrapping.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Gating with reset keeps the tick low while held in reset when PIX_DIV = 1.
    assign p_tick = (div_cnt == DIV_LAST) && !reset;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator and registered RGB/sync pin stage.
// Pins show the pixel at (h, v) one pixel period after the counters leave it.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int PIX_DIV  = VGA_PIX_DIV,
    parameter int H_DISP   = VGA_H_DISP,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_DISP   = VGA_V_DISP,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter bit SYNC_POL = VGA_SYNC_POL
) (
    input  logic       clk,
    input  logic       reset,
    input  rgb_t       rgb_in,
    output logic       p_tick,
    output coord_t     pix_x,
    output coord_t     pix_y,
    output logic       video_on,
    output logic       frame_tick,
    output logic [7:0] frame_cnt,
    output logic       hsync,
    output logic       vsync,
    output rgb_t       vga_rgb
);

    localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;

    localparam coord_t H_LAST  = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST  = coord_t'(V_TOTAL - 1);
    localparam coord_t H_VIS   = coord_t'(H_DISP);
    localparam coord_t V_VIS   = coord_t'(V_DISP);
    localparam coord_t HS_LO   = coord_t'(H_DISP + H_FP);
    localparam coord_t HS_HI   = coord_t'(H_DISP + H_FP + H_SYNC - 1);
    localparam coord_t VS_LO   = coord_t'(V_DISP + V_FP);
    localparam coord_t VS_HI   = coord_t'(V_DISP + V_FP + V_SYNC - 1);
    // Second blanking line: graphics updates here settle well before line 0.
    localparam coord_t FT_LINE = coord_t'(V_DISP + 1);

    coord_t h_cnt;
    coord_t v_cnt;
    logic   h_last;
    logic   v_last;
    logic   h_sync_act;
    logic   v_sync_act;

    vga_pix_div #(
        .PIX_DIV (PIX_DIV)
    ) u_pix_div (
        .clk    (clk),
        .reset  (reset),
        .p_tick (p_tick)
    );

    assign h_last = (h_cnt == H_LAST);
    assign v_last = (v_cnt == V_LAST);

    // Raster counters: h every pixel, v at end of line, frame_cnt at end of frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt     <= '0;
            v_cnt     <= '0;
            frame_cnt <= '0;
        end else if (p_tick) begin
            if (h_last) begin
                h_cnt <= '0;
                if (v_last) begin
                    v_cnt     <= '0;
                    frame_cnt <= frame_cnt + 8'd1;
                end else begin
                    v_cnt <= v_cnt + coord_t'(1);
                end
            end else begin
                h_cnt <= h_cnt + coord_t'(1);
            end
        end
    end

    // Visible-area, sync-window and frame-tick decode from the live counters.
    // NOTE: every output of this block is assigned on every pass, so no latch
    // can be inferred; add a default first if a conditional assignment appears.
    always_comb begin
        video_on   = (h_cnt < H_VIS) && (v_cnt < V_VIS);
        h_sync_act = in_window(h_cnt, HS_LO, HS_HI);
        v_sync_act = in_window(v_cnt, VS_LO, VS_HI);
        frame_tick = p_tick && (h_cnt == '0) && (v_cnt == FT_LINE);
    end

    // Pin stage: sync and blanked colour registered together on the pixel edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hsync   <= ~SYNC_POL;
            vsync   <= ~SYNC_POL;
            vga_rgb <= RGB_BLACK;
        end else if (p_tick) begin
            hsync   <= h_sync_act ? SYNC_POL : ~SYNC_POL;
            vsync   <= v_sync_act ? SYNC_POL : ~SYNC_POL;
            vga_rgb <= video_on ? rgb_in : RGB_BLACK;
        end
    end

    assign pix_x = h_cnt;
    assign pix_y = v_cnt;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench for vga_sync_gen: a full 640x480 instance for line-level
// timing, plus a reduced-geometry instance (PIX_DIV = 1) for frame-level checks.
module tb_vga_sync_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    logic        rst_big, rst_sml;
    logic [11:0] rgb_big, rgb_sml;
    logic        sml_done = 1'b0;

    logic [1:0]        rst_a;
    logic [1:0][11:0]  rgb_a;
    logic [1:0]        p_tick_a, video_on_a, frame_tick_a, hsync_a, vsync_a;
    logic [1:0][9:0]   pix_x_a, pix_y_a;
    logic [1:0][7:0]   fcnt_a;
    logic [1:0][11:0]  vga_rgb_a;

    assign rst_a = {rst_sml, rst_big};
    assign rgb_a = {rgb_sml, rgb_big};

    vga_sync_gen u_big (
        .clk        (clk),
        .reset      (rst_big),
        .rgb_in     (rgb_big),
        .p_tick     (p_tick_a[0]),
        .pix_x      (pix_x_a[0]),
        .pix_y      (pix_y_a[0]),
        .video_on   (video_on_a[0]),
        .frame_tick (frame_tick_a[0]),
        .frame_cnt  (fcnt_a[0]),
        .hsync      (hsync_a[0]),
        .vsync      (vsync_a[0]),
        .vga_rgb    (vga_rgb_a[0])
    );

    vga_sync_gen #(
        .PIX_DIV (1),
        .H_DISP  (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
        .V_DISP  (6), .V_FP (2), .V_SYNC (2), .V_BP (2)
    ) u_sml (
        .clk        (clk),
        .reset      (rst_sml),
        .rgb_in     (rgb_sml),
        .p_tick     (p_tick_a[1]),
        .pix_x      (pix_x_a[1]),
        .pix_y      (pix_y_a[1]),
        .video_on   (video_on_a[1]),
        .frame_tick (frame_tick_a[1]),
        .frame_cnt  (fcnt_a[1]),
        .hsync      (hsync_a[1]),
        .vsync      (vsync_a[1]),
        .vga_rgb    (vga_rgb_a[1])
    );

    // Reference model and pin scoreboard, one per instance, evaluated on negedge.
    for (genvar g = 0; g < 2; g++) begin : mon
        localparam int PD  = (g == 0) ? 4   : 1;
        localparam int HD  = (g == 0) ? 640 : 8;
        localparam int HT  = (g == 0) ? 800 : 16;
        localparam int HSS = (g == 0) ? 656 : 10;
        localparam int HSE = (g == 0) ? 751 : 12;
        localparam int VD  = (g == 0) ? 480 : 6;
        localparam int VT  = (g == 0) ? 525 : 12;
        localparam int VSS = (g == 0) ? 490 : 8;
        localparam int VSE = (g == 0) ? 491 : 9;
        localparam string PFX = (g == 0) ? "big." : "sml.";

        int          mh, mv, mdiv;
        logic [7:0]  mfc;
        logic [13:0] exp_q[$];
        logic [13:0] cur_pins;
        logic        pushed;
        logic        tick;
        logic        hs_e, vs_e;
        logic [11:0] rgb_e;

        always @(negedge clk) begin
            if (rst_a[g]) begin
                mh = 0; mv = 0; mdiv = 0; mfc = 8'd0;
                exp_q.delete();
                pushed   = 1'b0;
                cur_pins = {2'b11, 12'h000};
                check({PFX, "rst_pins"}, {hsync_a[g], vsync_a[g], vga_rgb_a[g]}, 14'h3000);
                check({PFX, "rst_ctl"}, {p_tick_a[g], frame_tick_a[g], video_on_a[g]}, 3'b001);
                check({PFX, "rst_cnt"}, {pix_x_a[g], pix_y_a[g], fcnt_a[g]}, 28'd0);
            end else begin
                if (pushed) begin
                    cur_pins = exp_q.pop_front();
                    pushed   = 1'b0;
                end
                check({PFX, "pins"}, {hsync_a[g], vsync_a[g], vga_rgb_a[g]}, cur_pins);
                tick = (mdiv == PD - 1);
                check({PFX, "p_tick"}, p_tick_a[g], tick);
                check({PFX, "pix"}, {pix_x_a[g], pix_y_a[g]}, {10'(mh), 10'(mv)});
                check({PFX, "frame_cnt"}, fcnt_a[g], mfc);
                check({PFX, "video_on"}, video_on_a[g], (mh < HD) && (mv < VD));
                check({PFX, "frame_tick"}, frame_tick_a[g], tick && (mh == 0) && (mv == VD + 1));
                if (tick) begin
                    hs_e  = !((mh >= HSS) && (mh <= HSE));
                    vs_e  = !((mv >= VSS) && (mv <= VSE));
                    rgb_e = ((mh < HD) && (mv < VD)) ? rgb_a[g] : 12'h000;
                    exp_q.push_back({hs_e, vs_e, rgb_e});
                    pushed = 1'b1;
                    if (mh == HT - 1) begin
                        mh = 0;
                        if (mv == VT - 1) begin
                            mv  = 0;
                            mfc = mfc + 8'd1;
                        end else begin
                            mv++;
                        end
                    end else begin
                        mh++;
                    end
                end
                mdiv = (mdiv == PD - 1) ? 0 : mdiv + 1;
            end
        end
    end

    // Full-size instance: release timing, one complete line, mid-line reset.
    initial begin
        int n, hs_low, vs_low, rgb_on, max_x, y_bad;
        rst_big = 1'b0;
        rgb_big = 12'habc;
        #3 rst_big = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst_big = 1'b0;

        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            if (k < 3)
                check("big.tick_early", {p_tick_a[0], pix_x_a[0]}, {1'b0, 10'd0});
            else if (k == 3)
                check("big.tick_first", {p_tick_a[0], pix_x_a[0]}, {1'b1, 10'd0});
            else
                check("big.first_adv", {p_tick_a[0], pix_x_a[0]}, {1'b0, 10'd1});
        end

        n = 0; hs_low = 0; vs_low = 0; rgb_on = 0; max_x = 0; y_bad = 0;
        @(negedge clk);
        while (!(pix_y_a[0] == 10'd1 && pix_x_a[0] == 10'd0) && n < 4000) begin
            if (!hsync_a[0]) hs_low++;
            if (!vsync_a[0]) vs_low++;
            if (vga_rgb_a[0] == 12'habc) rgb_on++;
            if (int'(pix_x_a[0]) > max_x) max_x = int'(pix_x_a[0]);
            if (pix_y_a[0] != 10'd0) y_bad++;
            n++;
            @(negedge clk);
        end
        check("big.line_budget", n < 4000, 1'b1);
        check("big.hsync_low_clks", hs_low, 96 * 4);
        check("big.vsync_low_clks", vs_low, 0);
        check("big.rgb_on_clks", rgb_on, 640 * 4);
        check("big.max_x", max_x, 799);
        check("big.y_before_wrap", y_bad, 0);

        n = 0;
        while (!(pix_y_a[0] == 10'd1 && pix_x_a[0] == 10'd300) && n < 2000) begin
            n++;
            @(negedge clk);
        end
        check("big.midline_budget", n < 2000, 1'b1);
        #2 rst_big = 1'b1;
        #1;
        check("big.async_pix", {pix_x_a[0], pix_y_a[0]}, 20'd0);
        check("big.async_pins", {hsync_a[0], vsync_a[0], vga_rgb_a[0]}, 14'h3000);
        check("big.async_ctl", {p_tick_a[0], frame_tick_a[0], video_on_a[0]}, 3'b001);
        repeat (3) @(posedge clk);
        #2 rst_big = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("big.restart", {pix_x_a[0], pix_y_a[0]}, {10'd1, 10'd0});

        // Colour changes every clk; only values present at a pixel edge may appear.
        repeat (2000) begin
            @(posedge clk);
            #1 rgb_big = 12'($urandom);
        end

        n = 0;
        while (!sml_done && n < 100000) begin
            n++;
            @(negedge clk);
        end
        check("sml.done_budget", sml_done, 1'b1);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Small-instance colour source: new random value just after every edge.
    initial begin
        rgb_sml = 12'h000;
        forever begin
            @(posedge clk);
            #1 rgb_sml = 12'($urandom);
        end
    end

    // Reduced-geometry instance: frame-level timing and frame counter wrap.
    initial begin
        int n, ft, ft_x, ft_y, vs_low, hs_low;
        rst_sml = 1'b0;
        #3 rst_sml = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst_sml = 1'b0;

        n = 0; ft = 0; ft_x = -1; ft_y = -1; vs_low = 0; hs_low = 0;
        @(negedge clk);
        while (fcnt_a[1] != 8'd1 && n < 400) begin
            if (frame_tick_a[1]) begin
                ft++;
                ft_x = int'(pix_x_a[1]);
                ft_y = int'(pix_y_a[1]);
            end
            if (!vsync_a[1]) vs_low++;
            if (!hsync_a[1]) hs_low++;
            n++;
            @(negedge clk);
        end
        check("sml.frame_budget", n < 400, 1'b1);
        check("sml.frame_clks", n, 16 * 12);
        check("sml.frame_ticks", ft, 1);
        check("sml.frame_tick_pos", {10'(ft_x), 10'(ft_y)}, {10'd0, 10'd7});
        check("sml.vsync_low_clks", vs_low, 2 * 16);
        check("sml.hsync_low_clks", hs_low, 3 * 12);
        check("sml.wrap_pix", {pix_x_a[1], pix_y_a[1]}, 20'd0);

        n = 0; ft = 0;
        while (fcnt_a[1] != 8'd0 && n < 50000) begin
            if (frame_tick_a[1]) ft++;
            n++;
            @(negedge clk);
        end
        check("sml.wrap_budget", n < 50000, 1'b1);
        check("sml.wrap_ticks", ft, 255);
        check("sml.wrap_cnt", {fcnt_a[1], pix_x_a[1], pix_y_a[1]}, 28'd0);

        n = 0;
        while (!(pix_x_a[1] == 10'd5 && pix_y_a[1] == 10'd3) && n < 400) begin
            n++;
            @(negedge clk);
        end
        check("sml.mid_budget", n < 400, 1'b1);
        #2 rst_sml = 1'b1;
        #1;
        check("sml.async_pix", {pix_x_a[1], pix_y_a[1], fcnt_a[1]}, 28'd0);
        check("sml.async_pins", {hsync_a[1], vsync_a[1], vga_rgb_a[1]}, 14'h3000);
        check("sml.async_ctl", {p_tick_a[1], frame_tick_a[1], video_on_a[1]}, 3'b001);
        repeat (2) @(posedge clk);
        #2 rst_sml = 1'b0;
        @(posedge clk);
        #1;
        check("sml.restart", {pix_x_a[1], pix_y_a[1]}, {10'd1, 10'd0});
        repeat (100) @(negedge clk);
        sml_done = 1'b1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "simulation timeout");
    end

endmodule
